// File: rtl/noc_tracker_pkg.sv
// Shared definitions for the NoC link tracker: error codes, framing FSM
// states, default header field positions and the error priority encoder.
package noc_tracker_pkg;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_EDGE      = 3'd1,
        ERR_UNDERFLOW = 3'd2,
        ERR_OVERFLOW  = 3'd3
    } err_code_e;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } frame_state_e;

    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_CREDITS    = 4;
    localparam int unsigned DEF_LEN_LSB    = 22;
    localparam int unsigned DEF_LEN_WIDTH  = 8;

    // Lowest error code wins when several conditions hit in the same cycle.
    function automatic err_code_e prio_err(input logic edge_err,
                                           input logic underflow,
                                           input logic overflow);
        if (edge_err)       return ERR_EDGE;
        else if (underflow) return ERR_UNDERFLOW;
        else if (overflow)  return ERR_OVERFLOW;
        else                return ERR_NONE;
    endfunction

endpackage

// File: rtl/noc_credit_tracker.sv
// Sender-side credit counter for one link: saturating at 0 and CREDITS,
// with combinational underflow/overflow detection for the current cycle.
module noc_credit_tracker #(
    parameter int unsigned CREDITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic       yummy_i,
    output logic [3:0] credits_o,
    output logic       underflow_o,
    output logic       overflow_o
);

    localparam logic [3:0] MAX_CREDITS = 4'(CREDITS);

    logic [3:0] credits_q, credits_d;

    // Next credit count: a flit consumes, a yummy returns, both cancel.
    always_comb begin
        credits_d = credits_q;
        if (valid_i && !yummy_i && (credits_q != '0)) begin
            credits_d = credits_q - 4'd1;
        end else if (yummy_i && !valid_i && (credits_q != MAX_CREDITS)) begin
            credits_d = credits_q + 4'd1;
        end
    end

    // Credit register, refilled on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= MAX_CREDITS;
        end else begin
            credits_q <= credits_d;
        end
    end

    assign underflow_o = valid_i && !yummy_i && (credits_q == '0);
    assign overflow_o  = yummy_i && !valid_i && (credits_q == MAX_CREDITS);
    assign credits_o   = credits_q;

endmodule

// File: rtl/noc_link_tracker.sv
// Checker for one directional NoC router output link (valid/data/yummy).
// Tracks credits, OpenPiton packet framing, and captures the first error.
// Optional statistics counters are built when NOC_TRACKER_STATS_EN is defined.
module noc_link_tracker
    import noc_tracker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CREDITS    = DEF_CREDITS,
    parameter int unsigned LEN_LSB    = DEF_LEN_LSB,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  link_valid,
    input  logic [DATA_WIDTH-1:0] link_data,
    input  logic                  link_yummy,
    input  logic                  port_allowed,
    input  logic                  clear,
    output logic                  err_valid,
    output logic [2:0]            err_code,
    output logic [DATA_WIDTH-1:0] err_header,
    output logic [3:0]            credits,
    output logic                  in_packet,
    output logic [31:0]           pkt_count,
    output logic [31:0]           flit_count
);

    frame_state_e          state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] cur_header_q, cur_header_d;
    logic [LEN_WIDTH-1:0]  hdr_len;

    logic                  err_valid_q, err_valid_d;
    err_code_e             err_code_q, err_code_d;
    logic [DATA_WIDTH-1:0] err_header_q, err_header_d;

    logic                  underflow, overflow, edge_err;
    err_code_e             cur_err;

    assign hdr_len = link_data[LEN_LSB +: LEN_WIDTH];

    noc_credit_tracker #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (link_valid),
        .yummy_i     (link_yummy),
        .credits_o   (credits),
        .underflow_o (underflow),
        .overflow_o  (overflow)
    );

    // Framing FSM next state: header opens a packet unless its length is zero.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        cur_header_d = cur_header_q;
        if (link_valid) begin
            case (state_q)
                IDLE: begin
                    cur_header_d = link_data;
                    if (hdr_len != '0) begin
                        state_d     = BODY;
                        remaining_d = hdr_len;
                    end
                end
                BODY: begin
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d     = IDLE;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Framing FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            cur_header_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            cur_header_q <= cur_header_d;
        end
    end

    assign edge_err = link_valid && !port_allowed;
    assign cur_err  = prio_err(edge_err, underflow, overflow);

    // Sticky capture of the first error; a new error beats a same-cycle clear.
    always_comb begin
        err_valid_d  = err_valid_q;
        err_code_d   = err_code_q;
        err_header_d = err_header_q;
        if ((cur_err != ERR_NONE) && (!err_valid_q || clear)) begin
            err_valid_d  = 1'b1;
            err_code_d   = cur_err;
            err_header_d = (state_q == IDLE) ? link_data : cur_header_q;
        end else if (clear) begin
            err_valid_d  = 1'b0;
            err_code_d   = ERR_NONE;
            err_header_d = '0;
        end
    end

    // Error capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_header_q <= '0;
        end else begin
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            err_header_q <= err_header_d;
        end
    end

    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_header = err_header_q;
    assign in_packet  = (state_q == BODY);

`ifdef NOC_TRACKER_STATS_EN
    logic        pkt_done;
    logic [31:0] pkt_count_q, flit_count_q;

    // Completion mirrors the FSM: zero-length header, or the last body flit.
    assign pkt_done = link_valid &&
                      (((state_q == IDLE) && (hdr_len == '0)) ||
                       ((state_q == BODY) && (remaining_q == LEN_WIDTH'(1))));

    // Free-running statistics counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q  <= '0;
            flit_count_q <= '0;
        end else begin
            if (pkt_done)   pkt_count_q  <= pkt_count_q + 32'd1;
            if (link_valid) flit_count_q <= flit_count_q + 32'd1;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign flit_count = flit_count_q;
`else
    assign pkt_count  = '0;
    assign flit_count = '0;
`endif

endmodule

// File: doc/noc_link_tracker.md
# noc_link_tracker

- Synthesizable checker for one directional NoC router output link (valid/data/yummy credit interface); one instance per tile edge port per NoC.
- Tracks sender-side credits and packet framing from the OpenPiton header length field.
- Flags flits that leave through a disallowed edge, credit underflow and credit overflow.
- Captures the first offending header in sticky registers for the network boundary monitor and debug readout.

## Interface
Parameters:
- DATA_WIDTH, 64: flit width.
- CREDITS, 4: receiver buffer depth (initial and maximum credit count), 1..15.
- LEN_LSB, 22: LSB of the payload-length field in a header flit.
- LEN_WIDTH, 8: width of the payload-length field.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- link_valid  in  1  flit transferred on link this cycle.
- link_data  in  DATA_WIDTH  flit.
- link_yummy  in  1  one credit returned by receiver this cycle.
- port_allowed  in  1  quasi-static; 0 = edge port, no traffic permitted.
- clear  in  1  synchronous clear of sticky error.
- err_valid  out  1  sticky error flag.
- err_code  out  3  1=EDGE, 2=UNDERFLOW, 3=OVERFLOW, 0=none.
- err_header  out  DATA_WIDTH  header of the packet owning the first error.
- credits  out  4  current credit count.
- in_packet  out  1  FSM in BODY.
- pkt_count  out  32  completed packets (NOC_TRACKER_STATS_EN only).
- flit_count  out  32  accepted flits (NOC_TRACKER_STATS_EN only).

## Operation
- Reset values: credits=CREDITS; FSM IDLE; err_valid=0; err_code=0; err_header=0; counters=0.
- Credits:
  - valid alone: decrement.
  - yummy alone: increment.
  - both: unchanged.
  - Saturate at 0 and CREDITS.
- Framing FSM:
  - IDLE, valid: flit is header; latch cur_header; len = link_data[LEN_LSB+:LEN_WIDTH].
    - len==0: stay IDLE, packet complete.
    - else: go BODY with remaining=len.
  - BODY, valid: remaining decrements; flit with remaining==1 completes packet, back to IDLE.
  - No valid: state holds.
- Error detection, evaluated per cycle:
  - EDGE: valid while port_allowed==0.
  - UNDERFLOW: valid while credits==0 and no yummy.
  - OVERFLOW: yummy while credits==CREDITS and no valid.
  - Simultaneous errors: lowest code wins.
- Error capture:
  - Only when err_valid==0; later errors are ignored until clear.
  - err_header = link_data if in IDLE, else cur_header.
  - clear asserted together with a new error: the new error is captured (clear loses).
- Erroneous flits still advance the FSM and counters.

## Timing
- All outputs registered; effect of a cycle-N input is visible after the rising edge ending cycle N.
- Zero-length packet: complete in the same cycle as its header.
- remaining width LEN_WIDTH; max packet = 2^LEN_WIDTH-1 body flits, no wrap.
- rst mid-packet: FSM to IDLE, credits refilled, error cleared; the next valid flit is treated as a header.
- Counters wrap at 2^32.

## Configuration
- NOC_TRACKER_STATS_EN defined:
  - pkt_count increments on each packet completion.
  - flit_count increments on each valid.
- NOC_TRACKER_STATS_EN undefined:
  - Counter registers are not built.
  - pkt_count and flit_count tie to 0; ports remain present.

## Structure
- Shared package (noc_tracker_pkg):
  - Error-code constants ERR_NONE/EDGE/UNDERFLOW/OVERFLOW.
  - FSM state constants IDLE/BODY.
  - Default header field positions.
- One natural sub-module: noc_credit_tracker (credit counter with saturation plus underflow/overflow detection).
- Framing FSM, error capture and stats live in the top.

## Test plan
- CREDITS=4, port_allowed=1; send header len=2 plus 2 body flits, yummy each flit next cycle -> credits 4→3→… back to 4; pkt_count=1, flit_count=3, err_valid=0.
- 5 valid flits with no yummy -> 5th flit gives err_valid=1, err_code=2, err_header = that packet's header; credits stays 0.
- Idle with credits=4, pulse yummy -> err_code=3, err_header=0 (IDLE, data 0).
- port_allowed=0, header 0xABCD flit with len=0 -> err_code=1, err_header=0xABCD; a second error later leaves both unchanged. Then clear -> err_valid=0, err_code=0.
- Valid+yummy same cycle at credits=0 -> no error, credits=0. Then rst asserted mid-BODY -> in_packet=0, credits=4 immediately (async).
- Build without NOC_TRACKER_STATS_EN, run the first scenario -> pkt_count=flit_count=0; all other outputs identical.
